// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO: 32-step shift-add multiply or
// restoring divide on one shared 33-bit adder, with stall generation for the core.
module muldiv_unit (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [1:0]  i_op,
    input  logic [31:0] i_srca,
    input  logic [31:0] i_srcb,
    input  logic        i_mthi,
    input  logic        i_mtlo,
    input  logic [31:0] i_wd,
    input  logic        i_rd_req,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_stall
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t      r_state;
    logic [4:0]  r_count;
    logic [31:0] r_acc;     // multiply: high accumulator; divide: partial remainder
    logic [31:0] r_aux;     // multiply: multiplier/low product; divide: dividend/quotient
    logic [31:0] r_opnd;    // multiplicand or divisor magnitude
    logic [31:0] r_srca;
    logic        r_is_div;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_div0;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;

    logic        w_signed;
    logic        w_sa;
    logic        w_sb;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [32:0] w_add_a;
    logic [32:0] w_add_b;
    logic [33:0] w_sum;
    logic [32:0] w_madd;
    logic [63:0] w_prod;
    logic [63:0] w_prod_neg;
    logic [31:0] w_quo_neg;
    logic [31:0] w_rem_neg;

    assign w_signed = ~i_op[0];
    assign w_sa     = w_signed & i_srca[31];
    assign w_sb     = w_signed & i_srcb[31];
    assign w_mag_a  = w_sa ? (~i_srca + 32'd1) : i_srca;
    assign w_mag_b  = w_sb ? (~i_srcb + 32'd1) : i_srcb;

    // Shared adder: subtract for divide via inverted operand and carry-in;
    // bit 33 then flags "no borrow" (shifted remainder >= divisor).
    assign w_add_a  = r_is_div ? {r_acc, r_aux[31]} : {1'b0, r_acc};
    assign w_add_b  = r_is_div ? ~{1'b0, r_opnd} : {1'b0, r_opnd};
    assign w_sum    = {1'b0, w_add_a} + {1'b0, w_add_b} + {33'd0, r_is_div};
    assign w_madd   = r_aux[0] ? w_sum[32:0] : {1'b0, r_acc};

    assign w_prod     = {r_acc, r_aux};
    assign w_prod_neg = ~w_prod + 64'd1;
    assign w_quo_neg  = ~r_aux + 32'd1;
    assign w_rem_neg  = ~r_acc + 32'd1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_count  <= 5'd0;
            r_acc    <= 32'd0;
            r_aux    <= 32'd0;
            r_opnd   <= 32'd0;
            r_srca   <= 32'd0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_mthi) r_hi <= i_wd;
                    if (i_mtlo) r_lo <= i_wd;
                    if (i_start) begin
                        r_is_div <= i_op[1];
                        r_neg_q  <= w_sa ^ w_sb;
                        r_neg_r  <= w_sa;
                        r_div0   <= i_op[1] & (i_srcb == 32'd0);
                        r_srca   <= i_srca;
                        r_count  <= 5'd0;
                        r_acc    <= 32'd0;
                        if (i_op[1]) begin
                            r_aux  <= w_mag_a;
                            r_opnd <= w_mag_b;
                        end else begin
                            r_aux  <= w_mag_b;
                            r_opnd <= w_mag_a;
                        end
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (r_is_div) begin
                        r_acc <= w_sum[33] ? w_sum[31:0] : {r_acc[30:0], r_aux[31]};
                        r_aux <= {r_aux[30:0], w_sum[33]};
                    end else begin
                        r_acc <= w_madd[32:1];
                        r_aux <= {w_madd[0], r_aux[31:1]};
                    end
                    r_count <= r_count + 5'd1;
                    if (r_count == 5'd31) r_state <= S_FIX;
                end
                S_FIX: begin
                    if (r_is_div) begin
                        if (r_div0) begin
                            r_lo <= 32'hFFFF_FFFF;
                            r_hi <= r_srca;
                        end else begin
                            r_lo <= r_neg_q ? w_quo_neg : r_aux;
                            r_hi <= r_neg_r ? w_rem_neg : r_acc;
                        end
                    end else begin
                        {r_hi, r_lo} <= r_neg_q ? w_prod_neg : w_prod;
                    end
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_hi    = r_hi;
    assign o_lo    = r_lo;
    assign o_done  = r_done;
    assign o_busy  = (r_state != S_IDLE);
    assign o_stall = o_busy & (i_start | i_rd_req | i_mthi | i_mtlo);
endmodule
